// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: a DATA register feeds a small byte FIFO
// that a bit-timed FSM drains onto txd; a CTRL/STATUS register reports FIFO state.
module uart_tx_port #(
  parameter int unsigned          BITS         = 32,
  parameter logic [BITS-1:0]      BASE         = 32'hF0000030,
  parameter logic [BITS-1:0]      CTRL_BASE    = 32'hF0000130,
  parameter int unsigned          CLKS_PER_BIT = 564,
  parameter int unsigned          FIFO_DEPTH   = 8,
  parameter int unsigned          FIFO_AW      = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  output logic            txd
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e             state_q;
  logic [TW-1:0]      timer_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               txd_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         last_q;

  logic fifo_empty, fifo_full, timer_done;
  logic data_wr, ctrl_wr, push, pop;
  logic [7:0] fifo_head;
  logic unused_bits;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == COUNT_FULL);
  assign timer_done = (timer_q == '0);
  assign fifo_head  = mem_q[rd_ptr_q];
  assign data_wr    = we && (memAddr == BASE);
  assign ctrl_wr    = we && (memAddr == CTRL_BASE);

  // The FSM takes a byte either from idle or at the last cycle of a stop bit,
  // so a pop frees a slot for a write landing on the same edge.
  assign pop  = !fifo_empty &&
                ((state_q == ST_IDLE) || ((state_q == ST_STOP) && timer_done));
  assign push = data_wr && (!fifo_full || pop);

  // Upper write-data bits have no destination.
  assign unused_bits = ^dataBusIn[BITS-1:8];

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (ctrl_wr && !dataBusIn[3]) overflow_d = 1'b0;
    if (data_wr && !push)         overflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (data_wr) last_q   <= dataBusIn[7:0];
      if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dataBusIn[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shift_q <= fifo_head;
            timer_q <= BIT_LAST;
            txd_q   <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (timer_done) begin
            timer_q   <= BIT_LAST;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= ST_DATA;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (timer_done) begin
            timer_q <= BIT_LAST;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              txd_q     <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (timer_done) begin
            if (pop) begin
              shift_q <= fifo_head;
              timer_q <= BIT_LAST;
              txd_q   <= 1'b0;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign txd = txd_q;

  always_comb begin
    dataBusOut = '0;
    if (re && (memAddr == BASE)) begin
      dataBusOut[7:0] = last_q;
    end else if (re && (memAddr == CTRL_BASE)) begin
      dataBusOut[FIFO_AW+4:4] = count_q;
      dataBusOut[3]           = overflow_q;
      dataBusOut[2]           = fifo_empty;
      dataBusOut[1]           = fifo_full;
      dataBusOut[0]           = (state_q != ST_IDLE) || !fifo_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a frame-timeline model (queue of bytes plus the
// position inside the current 10-bit frame) predicts txd and status every cycle.
module tb_uart_tx_port;

  localparam int          CPB       = 4;
  localparam int          DEPTH     = 8;
  localparam int          FRAME     = 10 * CPB;
  localparam logic [31:0] BASE      = 32'hF0000030;
  localparam logic [31:0] CTRL_BASE = 32'hF0000130;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re;
  logic [31:0] memAddr, dataBusIn, dataBusOut;
  logic        txd;

  uart_tx_port #(
    .BITS(32), .BASE(BASE), .CTRL_BASE(CTRL_BASE),
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(3)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
    .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes waiting, the byte on the line, and cycles into its frame.
  logic [7:0] q[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;
  logic [7:0] m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0;
    m_pos    = 0;
    m_cur    = '0;
    m_ovf    = 0;
    m_last   = '0;
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit frame_end, pop, set_ovf;
    frame_end = m_active && (m_pos == FRAME - 1);
    pop       = (q.size() != 0) && (!m_active || frame_end);
    set_ovf   = 0;
    if (pop) begin
      m_cur = q.pop_front();
      m_active = 1;
      m_pos = 0;
    end else if (frame_end) begin
      m_active = 0;
    end else if (m_active) begin
      m_pos++;
    end
    if (we && memAddr == BASE) begin
      m_last = dataBusIn[7:0];
      if (q.size() < DEPTH) q.push_back(dataBusIn[7:0]);
      else set_ovf = 1;
    end
    if (set_ovf) m_ovf = 1;
    else if (we && memAddr == CTRL_BASE && !dataBusIn[3]) m_ovf = 0;
  endtask

  function automatic logic exp_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_pos / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  function automatic logic [31:0] exp_status();
    int n = q.size();
    logic [31:0] s;
    s    = 32'(n) << 4;
    s[3] = m_ovf;
    s[2] = (n == 0);
    s[1] = (n == DEPTH);
    s[0] = m_active || (n != 0);
    return s;
  endfunction

  task automatic read_check(input string tag, input logic rd, input logic [31:0] addr,
                            input logic [31:0] exp);
    re = rd;
    memAddr = addr;
    #1;
    check(tag, dataBusOut, exp);
    re = 1'b0;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    we = 1'b0;
    check("txd", {31'b0, txd}, {31'b0, exp_txd()});
    read_check("status", 1'b1, CTRL_BASE, exp_status());
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    memAddr = addr;
    dataBusIn = data;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && (m_active || q.size() != 0); i++) tick();
    if (m_active || q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    int r;
    logic [31:0] unmapped[4];
    unmapped = '{32'h0, BASE + 32'd4, CTRL_BASE - 32'd4, 32'hF0000031};
    model_reset();
    reset = 1'b1; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;
    #2 reset = 1'b0;
    #1 check("reset_txd", {31'b0, txd}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;

    read_check("idle_ctrl", 1'b1, CTRL_BASE, 32'h0000_0004);
    read_check("base_re0", 1'b0, BASE, 32'h0);
    foreach (unmapped[i]) read_check("unmapped", 1'b1, unmapped[i], 32'h0);

    // Single 0x55 frame, then idle.
    bus_write(BASE, 32'h0000_0055);
    read_check("data_rb", 1'b1, BASE, 32'h0000_0055);
    wait_idle(3 * FRAME);
    repeat (3) tick();

    // Three back-to-back frames.
    bus_write(BASE, 32'hA1);
    bus_write(BASE, 32'hB2);
    bus_write(BASE, 32'hC3);
    wait_idle(5 * FRAME);

    // Overfill during a frame, then clear the sticky overflow.
    bus_write(BASE, 32'h3C);
    tick();
    for (int i = 0; i < 9; i++) bus_write(BASE, 32'($urandom_range(0, 255)));
    bus_write(CTRL_BASE, 32'hFFFF_FFFF);
    bus_write(CTRL_BASE, 32'h0000_0000);

    // Full FIFO plus a write on the STOP-to-START pop edge.
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == FRAME - 1); i++) tick();
    if (!(m_active && m_pos == FRAME - 1)) check("boundary_wait", 32'd0, 32'd1);
    bus_write(BASE, 32'h0000_00E7);
    wait_idle(12 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6)       bus_write(BASE, $urandom());
      else if (r < 8)  bus_write(CTRL_BASE, $urandom());
      else if (r < 11) read_check("data_rb", 1'b1, BASE, {24'b0, m_last});
      else if (r < 13) read_check("unmapped", 1'b1, unmapped[$urandom_range(0, 3)], 32'h0);
      else             tick();
    end
    wait_idle(12 * FRAME);

    // Reset in the middle of a data bit of an all-zero byte.
    bus_write(BASE, 32'h0000_0000);
    bus_write(BASE, 32'h0000_00FF);
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == CPB + CPB / 2); i++) tick();
    check("pre_reset_low", {31'b0, txd}, 32'd0);
    #2 reset = 1'b0;
    #1 check("async_txd", {31'b0, txd}, 32'd1);
    model_reset();
    read_check("reset_ctrl", 1'b1, CTRL_BASE, 32'h0000_0004);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2 * FRAME) tick();
    read_check("post_reset_ctrl", 1'b1, CTRL_BASE, 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
